// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock, rounds 0..10.
// Define KEYEXP_STORE_EN to add an 11-entry round-key store with a read port.

module sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    logic [7:0] p;
    logic [7:0] inv;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] q;
        acc = 8'h00;
        q   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ q;
            q = xtime(q);
        end
        return acc;
    endfunction

    // Inverse in GF(2^8) as x^254, built from x^2..x^128; zero maps to zero.
    always_comb begin
        p   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        y = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
    end

endmodule

module key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] keyIn,
    output logic [127:0] keyOut,
    output logic [3:0]   roundNum,
    output logic         keyValid,
    output logic         busy,
    output logic         done
`ifdef KEYEXP_STORE_EN
    ,
    input  logic [3:0]   rdAddr,
    output logic [127:0] rdKey
`endif
);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t       state;
    state_t       state_next;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic [7:0]   rcon_q;
    logic         last;
    logic         accept;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [31:0]  temp;
    logic [31:0]  w4, w5, w6, w7;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    assign last   = (state == EXPAND) && (round_q == 4'd10);
    // A new start is taken in the done cycle too, so schedules can abut.
    assign accept = start && ((state == IDLE) || last);

    assign rot = {key_q[23:0], key_q[31:24]};

    sbox u_sb3 (.x(rot[31:24]), .y(sub[31:24]));
    sbox u_sb2 (.x(rot[23:16]), .y(sub[23:16]));
    sbox u_sb1 (.x(rot[15:8]),  .y(sub[15:8]));
    sbox u_sb0 (.x(rot[7:0]),   .y(sub[7:0]));

    assign temp = sub ^ {rcon_q, 24'h0};
    assign w4   = key_q[127:96] ^ temp;
    assign w5   = key_q[95:64]  ^ w4;
    assign w6   = key_q[63:32]  ^ w5;
    assign w7   = key_q[31:0]   ^ w6;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start) state_next = EXPAND;
            EXPAND: if (last)  state_next = start ? EXPAND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else if (accept) begin
            key_q   <= keyIn;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else if ((state == EXPAND) && !last) begin
            key_q   <= {w4, w5, w6, w7};
            round_q <= round_q + 4'd1;
            rcon_q  <= xtime(rcon_q);
        end
    end

    always_comb begin
        keyOut   = key_q;
        roundNum = round_q;
        keyValid = (state == EXPAND);
        busy     = (state == EXPAND);
        done     = last;
    end

`ifdef KEYEXP_STORE_EN
    logic [127:0] store [11];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) store[i] <= '0;
        end else if (state == EXPAND) begin
            store[round_q] <= key_q;
        end
    end

    assign rdKey = (rdAddr <= 4'd10) ? store[rdAddr] : '0;
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Randomised and known-answer bench for key_expansion against a
// word-array FIPS-197 key schedule model using a tabulated S-box.

module tb_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] keyIn;
    logic [127:0] keyOut;
    logic [3:0]   roundNum;
    logic         keyValid;
    logic         busy;
    logic         done;
`ifdef KEYEXP_STORE_EN
    logic [3:0]   rdAddr;
    logic [127:0] rdKey;
`endif

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_k [11];

    logic [7:0] sb [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic [7:0] rcon_tab [10] = '{
        8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36
    };

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expansion dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .keyIn    (keyIn),
        .keyOut   (keyOut),
        .roundNum (roundNum),
        .keyValid (keyValid),
        .busy     (busy),
        .done     (done)
`ifdef KEYEXP_STORE_EN
        ,
        .rdAddr   (rdAddr),
        .rdKey    (rdKey)
`endif
    );

    always #5 clk = ~clk;

    // FIPS-197 KeyExpansion over a flat 44-word array.
    task automatic model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rcon_tab[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; keyIn = '0;
`ifdef KEYEXP_STORE_EN
        rdAddr = '0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({keyOut, roundNum, keyValid, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h/%0d v%b b%b d%b required all 0",
                     keyOut, roundNum, keyValid, busy, done);
        end
    endtask

    task automatic test_known_keys();
        logic [127:0] keys [2];
        logic [127:0] r1 [2];
        logic [127:0] r10 [2];
        keys[0] = FIPS_KEY; r1[0] = FIPS_R1; r10[0] = FIPS_R10;
        keys[1] = '0;       r1[1] = ZERO_R1; r10[1] = ZERO_R10;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            keyIn = keys[n]; start = 1'b1;
            @(negedge clk);
            start = 1'b0; keyIn = rand128();
            for (int r = 0; r < 11; r++) begin
                checks++;
                if (r == 0 && keyOut !== keys[n]) begin
                    errors++;
                    $display("FAIL known%0d_round0: got %h required %h", n, keyOut, keys[n]);
                end
                if (r == 1 && keyOut !== r1[n]) begin
                    errors++;
                    $display("FAIL known%0d_round1: got %h required %h", n, keyOut, r1[n]);
                end
                if (r == 10 && keyOut !== r10[n]) begin
                    errors++;
                    $display("FAIL known%0d_round10: got %h required %h", n, keyOut, r10[n]);
                end
                checks++;
                if ({roundNum, keyValid, busy, done} !== {4'(r), 1'b1, 1'b1, (r == 10)}) begin
                    errors++;
                    $display("FAIL known%0d_ctrl r%0d: got rn%0d v%b b%b d%b required rn%0d v1 b1 d%b",
                             n, r, roundNum, keyValid, busy, done, r, (r == 10));
                end
                @(negedge clk);
            end
            checks++;
            if ({keyValid, busy, done} !== 3'b000 || keyOut !== r10[n] || roundNum !== 4'd10) begin
                errors++;
                $display("FAIL known%0d_idle_hold: got %h rn%0d v%b b%b d%b required %h rn10 v0 b0 d0",
                         n, keyOut, roundNum, keyValid, busy, done, r10[n]);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] k;
        for (int n = 0; n < 6; n++) begin
            k = rand128();
            model(k);
            @(negedge clk);
            keyIn = k; start = 1'b1;
            @(negedge clk);
            start = 1'b0; keyIn = rand128();
            for (int r = 0; r < 11; r++) begin
                checks++;
                if (keyOut !== exp_k[r] || roundNum !== 4'(r) || done !== (r == 10)) begin
                    errors++;
                    $display("FAIL random%0d r%0d: got %h rn%0d d%b required %h rn%0d d%b",
                             n, r, keyOut, roundNum, done, exp_k[r], r, (r == 10));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [127:0] k;
        k = rand128();
        model(k);
        @(negedge clk);
        keyIn = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (keyOut !== exp_k[r] || busy !== 1'b1 || keyValid !== 1'b1) begin
                errors++;
                $display("FAIL ignore_start r%0d: got %h b%b v%b required %h b1 v1",
                         r, keyOut, busy, keyValid, exp_k[r]);
            end
            if (r == 4) begin
                start = 1'b1; keyIn = ~k;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_len: busy got %b after 11 cycles required 0", busy);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] k;
        k = rand128();
        model(k);
        @(negedge clk);
        keyIn = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (roundNum !== 4'd6) begin
            errors++;
            $display("FAIL async_pre: roundNum got %0d required 6", roundNum);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({keyOut, roundNum, keyValid, busy, done} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h/%0d v%b b%b d%b required all 0",
                     keyOut, roundNum, keyValid, busy, done);
        end
        #1 rst = 1'b0;
        k = rand128();
        model(k);
        @(negedge clk);
        keyIn = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (keyOut !== exp_k[r] || roundNum !== 4'(r) || done !== (r == 10)) begin
                errors++;
                $display("FAIL after_reset r%0d: got %h rn%0d d%b required %h rn%0d d%b",
                         r, keyOut, roundNum, done, exp_k[r], r, (r == 10));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        int run;
        int best;
        int ndone;
        int first_done;
        int second_done;
        int keybad;
        k = rand128();
        model(k);
        run = 0; best = 0; ndone = 0; first_done = -1; second_done = -1; keybad = 0;
        @(negedge clk);
        keyIn = k; start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 26; c++) begin
            if (keyValid) begin
                run++;
                if (run > best) best = run;
                if (keyOut !== exp_k[c % 11] || roundNum !== 4'(c % 11)) keybad++;
            end else begin
                run = 0;
            end
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == 11) start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (best !== 22) begin
            errors++;
            $display("FAIL b2b_valid_run: got %0d cycles required 22", best);
        end
        checks++;
        if (ndone !== 2 || second_done - first_done !== 11) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses at %0d,%0d required 2 pulses 11 apart",
                     ndone, first_done, second_done);
        end
        checks++;
        if (keybad !== 0) begin
            errors++;
            $display("FAIL b2b_keys: got %0d bad rounds required 0", keybad);
        end
    endtask

`ifdef KEYEXP_STORE_EN
    task automatic test_store();
        model(FIPS_KEY);
        @(negedge clk);
        keyIn = FIPS_KEY; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rdAddr = 4'd10; #1;
        checks++;
        if (rdKey !== FIPS_R10) begin
            errors++;
            $display("FAIL store_r10: got %h required %h", rdKey, FIPS_R10);
        end
        rdAddr = 4'd0; #1;
        checks++;
        if (rdKey !== FIPS_KEY) begin
            errors++;
            $display("FAIL store_r0: got %h required %h", rdKey, FIPS_KEY);
        end
        rdAddr = 4'd15; #1;
        checks++;
        if (rdKey !== '0) begin
            errors++;
            $display("FAIL store_oob: got %h required 0", rdKey);
        end
        for (int a = 1; a < 10; a++) begin
            rdAddr = 4'(a); #1;
            checks++;
            if (rdKey !== exp_k[a]) begin
                errors++;
                $display("FAIL store_r%0d: got %h required %h", a, rdKey, exp_k[a]);
            end
        end
        @(negedge clk);
        rst = 1'b1; #2 rst = 1'b0;
        rdAddr = 4'd5; #1;
        checks++;
        if (rdKey !== '0) begin
            errors++;
            $display("FAIL store_reset: got %h required 0", rdKey);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_known_keys();
        test_random();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
`ifdef KEYEXP_STORE_EN
        test_store();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
